// File: rtl/fmul_rr_if.sv
// Request/result bundle between the sincos requesters and the shared FMUL arbiter.
// master: requesters and result consumer. slave: the arbiter.
interface fmul_rr_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FRAC_WIDTH = 40,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_sign_a;
  logic [NUM_REQ-1:0]            req_sign_b;
  logic [NUM_REQ*EXP_WIDTH-1:0]  req_exp_a;
  logic [NUM_REQ*EXP_WIDTH-1:0]  req_exp_b;
  logic [NUM_REQ*FRAC_WIDTH-1:0] req_frac_a;
  logic [NUM_REQ*FRAC_WIDTH-1:0] req_frac_b;

  logic                          res_valid;
  logic                          res_ready;
  logic [ID_WIDTH-1:0]           res_id;
  logic                          res_sign;
  logic [EXP_WIDTH-1:0]          res_exp;
  logic [FRAC_WIDTH-1:0]         res_frac;
  logic                          busy;

  modport master (
    output req_valid, req_sign_a, req_sign_b, req_exp_a, req_exp_b, req_frac_a, req_frac_b,
    output res_ready,
    input  req_ready, res_valid, res_id, res_sign, res_exp, res_frac, busy
  );

  modport slave (
    input  req_valid, req_sign_a, req_sign_b, req_exp_a, req_exp_b, req_frac_a, req_frac_b,
    input  res_ready,
    output req_ready, res_valid, res_id, res_sign, res_exp, res_frac, busy
  );
endinterface

// File: rtl/fmul_rr_arbiter.sv
// Round-robin arbiter sharing one combinational FMUL among NUM_REQ requesters.
// Two-stage pipeline: S1 operand register, S2 result register with back-pressure.
module fmul_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FRAC_WIDTH = 40,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned ID_WIDTH   = 2
) (
  input logic      i_clk,
  input logic      i_rst_n,
  fmul_rr_if.slave bus
);

  localparam int unsigned PROD_WIDTH = 2 * FRAC_WIDTH;
  localparam int unsigned SUM_WIDTH  = ID_WIDTH + 1;
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO = {1'b1, {(EXP_WIDTH-1){1'b0}}};
  localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);

  logic                  run;
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic                  s1_valid;
  logic [ID_WIDTH-1:0]   s1_id;
  logic                  s1_sign_a, s1_sign_b;
  logic [EXP_WIDTH-1:0]  s1_exp_a, s1_exp_b;
  logic [FRAC_WIDTH-1:0] s1_frac_a, s1_frac_b;

  logic                  s2_valid;
  logic [ID_WIDTH-1:0]   s2_id;
  logic                  s2_sign;
  logic [EXP_WIDTH-1:0]  s2_exp;
  logic [FRAC_WIDTH-1:0] s2_frac;
  logic                  busy;

  logic                  adv, acc, take;
  logic                  s1_valid_d, s2_valid_d;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_any;
  logic [SUM_WIDTH-1:0]  idx_sum;

  logic                  fm_sign;
  logic [EXP_WIDTH-1:0]  fm_exp;
  logic [FRAC_WIDTH-1:0] fm_frac;
  logic [PROD_WIDTH-1:0] prod;

  logic                  sign_a_arr [NUM_REQ];
  logic                  sign_b_arr [NUM_REQ];
  logic [EXP_WIDTH-1:0]  exp_a_arr  [NUM_REQ];
  logic [EXP_WIDTH-1:0]  exp_b_arr  [NUM_REQ];
  logic [FRAC_WIDTH-1:0] frac_a_arr [NUM_REQ];
  logic [FRAC_WIDTH-1:0] frac_b_arr [NUM_REQ];

  // Unpack the per-requester operand slices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign sign_a_arr[g] = bus.req_sign_a[g];
    assign sign_b_arr[g] = bus.req_sign_b[g];
    assign exp_a_arr[g]  = bus.req_exp_a[g*EXP_WIDTH +: EXP_WIDTH];
    assign exp_b_arr[g]  = bus.req_exp_b[g*EXP_WIDTH +: EXP_WIDTH];
    assign frac_a_arr[g] = bus.req_frac_a[g*FRAC_WIDTH +: FRAC_WIDTH];
    assign frac_b_arr[g] = bus.req_frac_b[g*FRAC_WIDTH +: FRAC_WIDTH];
  end

  assign adv        = !s2_valid || bus.res_ready;
  assign acc        = adv || !s1_valid;
  assign take       = run && acc && grant_any;
  assign s2_valid_d = adv ? s1_valid : s2_valid;
  assign s1_valid_d = acc ? take : s1_valid;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_sum = {1'b0, rr_ptr} + SUM_WIDTH'(i);
      if (idx_sum >= SUM_WIDTH'(NUM_REQ)) idx_sum = idx_sum - SUM_WIDTH'(NUM_REQ);
      if (!grant_any && bus.req_valid[idx_sum[ID_WIDTH-1:0]]) begin
        grant[idx_sum[ID_WIDTH-1:0]] = 1'b1;
        grant_id                     = idx_sum[ID_WIDTH-1:0];
        grant_any                    = 1'b1;
      end
    end
  end

  // Ready is held low until the first edge after reset release.
  assign bus.req_ready = (run && acc) ? grant : '0;

  // FMUL on the S1 operands; a clear mantissa MSB encodes zero.
  always_comb begin
    prod    = PROD_WIDTH'(s1_frac_a) * PROD_WIDTH'(s1_frac_b);
    fm_sign = s1_sign_a ^ s1_sign_b;
    fm_exp  = s1_exp_a + s1_exp_b;
    fm_frac = prod[PROD_WIDTH-2 -: FRAC_WIDTH];
    if (prod[PROD_WIDTH-1]) begin
      fm_frac = prod[PROD_WIDTH-1 -: FRAC_WIDTH];
      fm_exp  = s1_exp_a + s1_exp_b + EXP_WIDTH'(1);
    end else if (!s1_frac_a[FRAC_WIDTH-1] || !s1_frac_b[FRAC_WIDTH-1]) begin
      fm_exp  = EXP_ZERO;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run       <= 1'b0;
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_exp_a  <= '0;
      s1_exp_b  <= '0;
      s1_frac_a <= '0;
      s1_frac_b <= '0;
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_sign   <= 1'b0;
      s2_exp    <= '0;
      s2_frac   <= '0;
      busy      <= 1'b0;
    end else begin
      run  <= 1'b1;
      busy <= s1_valid_d || s2_valid_d;
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_id   <= s1_id;
          s2_sign <= fm_sign;
          s2_exp  <= fm_exp;
          s2_frac <= fm_frac;
        end
      end
      if (acc) begin
        s1_valid <= take;
        if (take) begin
          s1_id     <= grant_id;
          s1_sign_a <= sign_a_arr[grant_id];
          s1_sign_b <= sign_b_arr[grant_id];
          s1_exp_a  <= exp_a_arr[grant_id];
          s1_exp_b  <= exp_b_arr[grant_id];
          s1_frac_a <= frac_a_arr[grant_id];
          s1_frac_b <= frac_b_arr[grant_id];
        end
      end
      if (take) rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
    end
  end

  assign bus.res_valid = s2_valid;
  assign bus.res_id    = s2_id;
  assign bus.res_sign  = s2_sign;
  assign bus.res_exp   = s2_exp;
  assign bus.res_frac  = s2_frac;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_fmul_rr_arbiter.sv
// Scoreboard bench for fmul_rr_arbiter: handshakes push expected results,
// result pops compare them, directed phases check latency, fairness and stalls.
module tb_fmul_rr_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned FW = 40;
  localparam int unsigned EW = 8;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          sign;
    logic [EW-1:0] exp;
    logic [FW-1:0] frac;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmul_rr_if #(.NUM_REQ(NR), .FRAC_WIDTH(FW), .EXP_WIDTH(EW), .ID_WIDTH(IW)) bus ();

  fmul_rr_arbiter #(.NUM_REQ(NR), .FRAC_WIDTH(FW), .EXP_WIDTH(EW), .ID_WIDTH(IW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic          sa_arr [NR];
  logic          sb_arr [NR];
  logic [EW-1:0] ea_arr [NR];
  logic [EW-1:0] eb_arr [NR];
  logic [FW-1:0] fa_arr [NR];
  logic [FW-1:0] fb_arr [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign bus.req_sign_a[g]           = sa_arr[g];
    assign bus.req_sign_b[g]           = sb_arr[g];
    assign bus.req_exp_a[g*EW +: EW]   = ea_arr[g];
    assign bus.req_exp_b[g*EW +: EW]   = eb_arr[g];
    assign bus.req_frac_a[g*FW +: FW]  = fa_arr[g];
    assign bus.req_frac_b[g*FW +: FW]  = fb_arr[g];
  end

  res_t sb[$];
  int   grant_log[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   hs_count = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
    end
  endtask

  // Reference FMUL: normalised 1.x mantissas, zero flagged by a clear MSB.
  function automatic res_t model(input int k);
    res_t          r;
    logic [2*FW-1:0] p;
    p      = {{FW{1'b0}}, fa_arr[k]} * {{FW{1'b0}}, fb_arr[k]};
    r.id   = IW'(k);
    r.sign = sa_arr[k] ^ sb_arr[k];
    if (!fa_arr[k][FW-1] || !fb_arr[k][FW-1]) begin
      r.exp  = 8'h80;
      r.frac = p[2*FW-2 -: FW];
    end else if (p[2*FW-1]) begin
      r.exp  = ea_arr[k] + eb_arr[k] + 8'd1;
      r.frac = p[2*FW-1 -: FW];
    end else begin
      r.exp  = ea_arr[k] + eb_arr[k];
      r.frac = p[2*FW-2 -: FW];
    end
    return r;
  endfunction

  task automatic set_op(input int k, input logic sa, input logic sb_, input logic [EW-1:0] ea,
                        input logic [EW-1:0] eb, input logic [FW-1:0] fa, input logic [FW-1:0] fb);
    sa_arr[k] = sa; sb_arr[k] = sb_;
    ea_arr[k] = ea; eb_arr[k] = eb;
    fa_arr[k] = fa; fb_arr[k] = fb;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NR; k++) begin
      logic [FW-1:0] fa, fb;
      fa = {8'($urandom), 32'($urandom)};
      fb = {8'($urandom), 32'($urandom)};
      fa[FW-1] = ($urandom_range(0, 3) != 0);
      fb[FW-1] = ($urandom_range(0, 3) != 0);
      set_op(k, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), fa, fb);
    end
  endtask

  // Scoreboard: pop on result handshake, push on request handshake.
  always @(negedge clk) begin
    logic [NR-1:0] hs;
    res_t e;
    chk("rdy_onehot", 64'($onehot0(bus.req_ready)), 64'(1));
    chk("rdy_no_valid", 64'(bus.req_ready & ~bus.req_valid), 64'(0));
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(bus.res_valid), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("res_id",   64'(bus.res_id),   64'(e.id));
        chk("res_sign", 64'(bus.res_sign), 64'(e.sign));
        chk("res_exp",  64'(bus.res_exp),  64'(e.exp));
        chk("res_frac", 64'(bus.res_frac), 64'(e.frac));
      end
    end
    hs = bus.req_valid & bus.req_ready;
    if (rst_n && hs != '0) begin
      for (int k = 0; k < NR; k++) begin
        if (hs == (NR'(1) << k)) begin
          sb.push_back(model(k));
          grant_log.push_back(k);
          hs_count++;
        end
      end
    end
  end

  task automatic send(input int k);
    int waited;
    waited = 0;
    @(posedge clk); #1 bus.req_valid = NR'(1) << k;
    do begin
      @(negedge clk);
      waited++;
    end while ((bus.req_valid & bus.req_ready) == '0 && waited < 20);
    if (waited >= 20) chk("send_timeout", 64'(bus.req_ready), 64'(NR'(1) << k));
    @(posedge clk); #1 bus.req_valid = '0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || bus.busy) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  // Directed single transfer: S1 after one edge, result after the second.
  task automatic directed(input string tag, input int k, input logic sign,
                          input logic [EW-1:0] exp, input logic [FW-1:0] frac);
    send(k);
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(bus.res_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_lat2"}, 64'(bus.res_valid), 64'(1));
    chk({tag, "_id"},   64'(bus.res_id),    64'(k));
    chk({tag, "_sign"}, 64'(bus.res_sign),  64'(sign));
    chk({tag, "_exp"},  64'(bus.res_exp),   64'(exp));
    chk({tag, "_frac"}, 64'(bus.res_frac),  64'(frac));
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, hs_before;
    logic [IW-1:0] h_id;
    logic          h_sign;
    logic [EW-1:0] h_exp;
    logic [FW-1:0] h_frac;

    for (int k = 0; k < NR; k++) set_op(k, 1'b0, 1'b0, '0, '0, '0, '0);
    bus.res_ready = 1'b1;
    bus.req_valid = '1;

    // Reset with every requester asking.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_ready",     64'(bus.req_ready), 64'(0));
    chk("rst_busy",      64'(bus.busy),      64'(0));
    chk("rst_id",        64'(bus.res_id),    64'(0));
    chk("rst_sign",      64'(bus.res_sign),  64'(0));
    chk("rst_exp",       64'(bus.res_exp),   64'(0));
    chk("rst_frac",      64'(bus.res_frac),  64'(0));
    #2 rst_n = 1'b1;
    #1 chk("rel_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    chk("first_ready", 64'(bus.req_ready), 64'(4'b0001));
    @(posedge clk); #1 bus.req_valid = '0;
    drain();
    chk("first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));

    set_op(2, 1'b0, 1'b1, 8'h00, 8'h00, 40'h80_0000_0000, 40'h80_0000_0000);
    directed("one", 2, 1'b1, 8'h00, 40'h80_0000_0000);
    set_op(0, 1'b0, 1'b0, 8'h03, 8'hFF, 40'hC0_0000_0000, 40'hC0_0000_0000);
    directed("norm", 0, 1'b0, 8'h03, 40'h90_0000_0000);
    set_op(1, 1'b1, 1'b1, 8'h05, 8'h07, 40'h40_0000_0000, 40'h80_0000_0000);
    directed("zero", 1, 1'b0, 8'h80, 40'h40_0000_0000);
    set_op(3, 1'b1, 1'b0, 8'h7F, 8'h01, 40'hC0_0000_0000, 40'hC0_0000_0000);
    directed("wrap", 3, 1'b1, 8'h81, 40'h90_0000_0000);

    // Reset mid-flight discards S1/S2 contents.
    rand_ops();
    @(posedge clk); #1 bus.req_valid = '1;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    grant_log.delete();
    #1;
    chk("mid_rst_valid", 64'(bus.res_valid), 64'(0));
    chk("mid_rst_busy",  64'(bus.busy),      64'(0));
    chk("mid_rst_frac",  64'(bus.res_frac),  64'(0));
    @(negedge clk); #2 rst_n = 1'b1;

    // Fairness and throughput with all requesters valid.
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("fair_ready", 64'(bus.req_ready), 64'(NR'(1) << (i % NR)));
      if (i >= 2) chk("tput_valid", 64'(bus.res_valid), 64'(1));
      @(posedge clk); #1 rand_ops();
    end
    bus.req_valid = '0;
    drain();
    chk("fair_count", 64'(grant_log.size()), 64'(12));
    for (int i = 0; i < grant_log.size(); i++)
      chk("fair_order", 64'(grant_log[i]), 64'(i % NR));

    // Back-pressure: two accepts fill the pipe, then everything holds.
    rand_ops();
    @(posedge clk); #1 bus.res_ready = 1'b0; bus.req_valid = 4'b1010;
    acc_n = 0;
    h_id = '0; h_sign = 1'b0; h_exp = '0; h_frac = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != '0) acc_n++;
      if (c >= 2) begin
        chk("bp_ready", 64'(bus.req_ready), 64'(0));
        chk("bp_valid", 64'(bus.res_valid), 64'(1));
        if (c == 2) begin
          h_id = bus.res_id; h_sign = bus.res_sign; h_exp = bus.res_exp; h_frac = bus.res_frac;
        end else begin
          chk("bp_hold_id",   64'(bus.res_id),   64'(h_id));
          chk("bp_hold_sign", 64'(bus.res_sign), 64'(h_sign));
          chk("bp_hold_exp",  64'(bus.res_exp),  64'(h_exp));
          chk("bp_hold_frac", 64'(bus.res_frac), 64'(h_frac));
        end
      end
    end
    chk("bp_accepts", 64'(acc_n), 64'(2));
    @(posedge clk); #1 bus.res_ready = 1'b1;
    hs_before = hs_count;
    repeat (6) @(posedge clk);
    #1 bus.req_valid = '0;
    drain();
    chk("bp_resume", 64'(hs_count - hs_before), 64'(6));
    chk("sb_left", 64'(sb.size()), 64'(0));
    chk("end_busy", 64'(bus.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
